inst_fetch_buffer: RTL
======================

Name: inst_fetch_buffer

Overview:
- Instruction-fetch stage between program_counter and the decode stage.
- Turns the current PC into instruction-ROM requests and pairs each returned word with its PC.
- Buffers fetched instructions in a small FIFO so variable ROM latency and decode backpressure are absorbed.
- Drives program_counter's stall_i and discards wrong-path fetches when a jump is taken.

Parameters:
XLEN, `XLEN from defines.v (32), address/data width
FIFO_DEPTH, 2, instruction-queue entries; also the cap on outstanding ROM requests plus queued instructions

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, synchronous, active-low
pc_i  in  XLEN  current PC from program_counter.pc_o
flush_i  in  1  jump taken this cycle (same signal as program_counter.je_i)
stall_o  out  1  to program_counter.stall_i; 1 = hold PC
rom_req_o  out  1  fetch request valid
rom_addr_o  out  XLEN  fetch address, {pc_i[XLEN-1:2],2'b00}
rom_gnt_i  in  1  ROM accepted the request this cycle
rom_rvalid_i  in  1  response valid; in-order, latency ≥1 cycle after grant
rom_rdata_i  in  32  instruction word
id_valid_o  out  1  instruction available to decode
id_ready_i  in  1  decode accepts this cycle
id_inst_o  out  32  instruction at queue head
id_pc_o  out  XLEN  PC of id_inst_o

Behaviour:
- Reset (rst_ni=0 at clk edge):
  - Outstanding count, kill count and both queues are cleared.
  - Outputs held while rst_ni=0: id_valid_o=0, id_inst_o=32'h00000013, id_pc_o=0, rom_req_o=0, stall_o=1.
  - The ROM shares rst_ni and must not return responses for pre-reset requests.
- Issue, combinational:
  - pop = id_valid_o & id_ready_i.
  - credit = (outstanding + inst_cnt - pop) < FIFO_DEPTH.
  - rom_req_o = credit & ~flush_i & rst_ni.
- A handshake (rom_req_o & rom_gnt_i) pushes pc_i into the pending-PC queue (depth FIFO_DEPTH) and increments outstanding.
- stall_o = ~(rom_req_o & rom_gnt_i), so the PC advances exactly once per accepted request. On a jump, program_counter gives je priority over stall.
- Response (rom_rvalid_i):
  - If kill_cnt>0: decrement kill_cnt and outstanding, and drop the data.
  - Otherwise: pop the pending-PC head, push {pc,rdata} into the instruction queue, and decrement outstanding.
  - Queue space is guaranteed by the credit rule.
- Latency: with a 1-cycle ROM and id_ready_i=1, an instruction appears on id_* the cycle after its rvalid, i.e. 2 cycles after grant. Sustained throughput is 1 instruction/cycle.
- Output: id_valid_o = inst_cnt≠0. id_inst_o/id_pc_o show the head entry. When empty they show the NOP encoding and the last PC, and are don't-care.
- Flush (flush_i=1), next-state effects:
  - The instruction queue and pending-PC queue are emptied, and any pop in the same cycle is ignored.
  - kill_cnt <= outstanding minus (1 if rom_rvalid_i this cycle).
  - A response arriving in the flush cycle is dropped.
  - No request is issued in the flush cycle; the first post-flush request uses the jump target.
- Simultaneous events:
  - Push and pop in the same cycle leave inst_cnt unchanged.
  - A response and a grant in the same cycle leave outstanding unchanged.
  - A flush while kill_cnt>0 accumulates the new outstanding count into kill_cnt.
- Protocol error: rom_rvalid_i with outstanding=0 is ignored and fires a simulation assertion.
- Counter widths are $clog2(FIFO_DEPTH+1) bits; the credit rule keeps them from overflowing.

Decomposition:
- defines.v gets `NOP_INST (32'h00000013) and `IF_FIFO_DEPTH alongside `XLEN.
- One sub-module: fetch_fifo, a generic synchronous FIFO parameterised by WIDTH/DEPTH.
  - Ports: push, pop, clear, full, empty, count, head data.
  - Instantiated twice: the pending-PC queue (WIDTH=XLEN) and the instruction queue (WIDTH=XLEN+32).

Test Plan:
1. Reset rst_ni=0 for 2 cycles, then release; pc_i walks 0,4,8…; ROM gnt=1 with 1-cycle latency -> during reset rom_req_o=0 and id_valid_o=0; afterwards id_pc_o=0,4,8 on consecutive cycles with the matching rdata and no bubbles.
2. id_ready_i=0 from the start -> after 2 words are queued, rom_req_o=0 and stall_o=1, and pc_i holds at 8; raise id_ready_i -> 0x0, 0x4, 0x8 delivered in order with no duplicates.
3. ROM latency 3; flush_i for one cycle with 2 requests outstanding (0x10, 0x14) and pc_i becoming 0x100 -> both stale rvalids are dropped, and the first id_valid_o shows id_pc_o=0x100.
4. rom_gnt_i=0 for 3 cycles -> rom_req_o stays 1, stall_o=1 for 3 cycles, pc_i is unchanged, and the pending queue is not pushed.
5. flush_i in the same cycle as rom_rvalid_i and id_valid_o&id_ready_i -> that response is dropped, the queue is empty next cycle, and kill_cnt equals the remaining outstanding count.
6. rst_ni=0 mid-stream with 2 outstanding and 1 queued -> the next cycle has id_valid_o=0 and all counters 0, and the restart fetches from PC 0 correctly.

Source files
------------

// File: rtl/inst_fetch_buffer_pkg.sv
// Shared constants and types for the instruction-fetch buffer.
// DEF_* values mirror the core-wide XLEN / fetch-queue defaults.
package inst_fetch_buffer_pkg;

   localparam int          DEF_XLEN       = 32;
   localparam int          DEF_FIFO_DEPTH = 2;
   localparam logic [31:0] NOP_INST       = 32'h0000_0013;

   typedef enum logic [2:0] {
      RSP_NONE,
      RSP_KEEP,
      RSP_KILL,
      RSP_DROP,
      RSP_ERR
   } rsp_e;

endpackage

// File: rtl/inst_fetch_buffer_fifo.sv
// Generic synchronous FIFO with clear, used for pending PCs and fetched words.
// Head data is valid only while empty_o is low.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rptr_q];
   assign do_push = push_i & ~full_o & ~clear_i;
   assign do_pop  = pop_i & ~empty_o & ~clear_i;

   always_comb begin
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      if (clear_i) begin
         rptr_d = '0;
         wptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (do_push) wptr_d = nxt(wptr_q);
         if (do_pop)  rptr_d = nxt(rptr_q);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Fetch stage: issues ROM requests under a credit limit, pairs responses
// with their PC and queues them for decode; kills wrong-path fetches on jumps.
module inst_fetch_buffer
   import inst_fetch_buffer_pkg::*;
#(
   parameter int XLEN       = DEF_XLEN,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [XLEN-1:0] pc_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            rom_req_o,
   output logic [XLEN-1:0] rom_addr_o,
   input  logic            rom_gnt_i,
   input  logic            rom_rvalid_i,
   input  logic [31:0]     rom_rdata_i,
   output logic            id_valid_o,
   input  logic            id_ready_i,
   output logic [31:0]     id_inst_o,
   output logic [XLEN-1:0] id_pc_o
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [CW-1:0]    out_cnt_q, out_cnt_d;
   logic [CW-1:0]    kill_cnt_q, kill_cnt_d;
   logic [CW-1:0]    inst_cnt, pend_cnt;
   logic [XLEN-1:0]  last_pc_q, last_pc_d;
   logic [XLEN-1:0]  pend_pc, head_pc;
   logic [XLEN+31:0] inst_head;
   logic [31:0]      head_inst;
   logic [CW:0]      load;
   logic             pop, credit, gnt, rsp_hit, keep;
   logic             pend_full, pend_empty, inst_full, inst_empty;
   rsp_e             rsp;

   // Credit covers in-flight requests plus queued words, so the queue never overflows.
   assign pop        = id_valid_o & id_ready_i;
   assign load       = {1'b0, out_cnt_q} + {1'b0, inst_cnt} - {{CW{1'b0}}, pop};
   assign credit     = load < (CW+1)'(FIFO_DEPTH);
   assign rom_req_o  = credit & ~flush_i & rst_ni;
   assign rom_addr_o = {pc_i[XLEN-1:2], 2'b00};
   assign gnt        = rom_req_o & rom_gnt_i;
   assign stall_o    = ~gnt;

   always_comb begin
      rsp = RSP_NONE;
      if (rst_ni && rom_rvalid_i) begin
         if (out_cnt_q == '0)       rsp = RSP_ERR;
         else if (kill_cnt_q != '0) rsp = RSP_KILL;
         else if (flush_i)          rsp = RSP_DROP;
         else                       rsp = RSP_KEEP;
      end
   end

   assign rsp_hit = (rsp != RSP_NONE) && (rsp != RSP_ERR);
   assign keep    = (rsp == RSP_KEEP);

   always_comb begin
      out_cnt_d  = out_cnt_q + CW'(gnt) - CW'(rsp_hit);
      kill_cnt_d = kill_cnt_q - CW'(rsp == RSP_KILL);
      if (flush_i) kill_cnt_d = out_cnt_q - CW'(rsp_hit);
      last_pc_d  = (pop && !flush_i) ? head_pc : last_pc_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         out_cnt_q  <= '0;
         kill_cnt_q <= '0;
         last_pc_q  <= '0;
      end else begin
         out_cnt_q  <= out_cnt_d;
         kill_cnt_q <= kill_cnt_d;
         last_pc_q  <= last_pc_d;
      end
   end

   fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pend_q (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (gnt),
      .pop_i   (keep),
      .clear_i (flush_i),
      .data_i  (pc_i),
      .full_o  (pend_full),
      .empty_o (pend_empty),
      .count_o (pend_cnt),
      .head_o  (pend_pc)
   );

   fetch_fifo #(.WIDTH(XLEN + 32), .DEPTH(FIFO_DEPTH)) u_inst_q (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (keep),
      .pop_i   (pop),
      .clear_i (flush_i),
      .data_i  ({pend_pc, rom_rdata_i}),
      .full_o  (inst_full),
      .empty_o (inst_empty),
      .count_o (inst_cnt),
      .head_o  (inst_head)
   );

   assign head_pc    = inst_head[XLEN+31:32];
   assign head_inst  = inst_head[31:0];
   assign id_valid_o = rst_ni & ~inst_empty;
   assign id_inst_o  = id_valid_o ? head_inst : NOP_INST;
   assign id_pc_o    = !rst_ni ? '0 : (id_valid_o ? head_pc : last_pc_q);

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (rsp != RSP_ERR);
         assert (!(gnt && pend_full));
         assert (!(keep && (pend_empty || inst_full)));
         assert (pend_cnt == out_cnt_q - kill_cnt_q);
      end
   end

endmodule
